// File: rtl/wvb_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wvb_chan_arbiter
// Summary  : Round-robin lock arbiter that shares N_CHANNELS waveform buffers
//            with one single-channel consumer. It presents the locked channel
//            downstream as a virtual single-channel wvb interface.
//            Defining WVB_ARB_GRANT_CNT_EN adds per-channel 16-bit saturating
//            grant counters on the grant_cnt output.
// Revision : 1.0  initial release
// ============================================================================
module wvb_chan_arbiter #(
    parameter int N_CHANNELS   = 24,
    parameter int P_IDX_WIDTH  = 5,
    parameter int P_DATA_WIDTH = 170,
    parameter int P_HDR_WIDTH  = 113
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [N_CHANNELS-1:0]              chan_mask,
    input  logic [N_CHANNELS-1:0]              wvb_hdr_empty,
    input  logic [N_CHANNELS*P_HDR_WIDTH-1:0]  wvb_hdr_data,
    input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
    output logic [N_CHANNELS-1:0]              wvb_hdr_rdreq,
    output logic [N_CHANNELS-1:0]              wvb_rdreq,
    output logic [N_CHANNELS-1:0]              wvb_rddone,
    output logic                               dn_hdr_empty,
    output logic [P_HDR_WIDTH-1:0]             dn_hdr_data,
    output logic [P_DATA_WIDTH-1:0]            dn_data,
    output logic [P_IDX_WIDTH-1:0]             dn_chan,
    output logic                               dn_locked,
`ifdef WVB_ARB_GRANT_CNT_EN
    output logic [N_CHANNELS*16-1:0]           grant_cnt,
`endif
    input  logic                               dn_hdr_rdreq,
    input  logic                               dn_rdreq,
    input  logic                               dn_rddone
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_lock = 2'd1;
    localparam logic [1:0] c_rel  = 2'd2;

    localparam logic [P_IDX_WIDTH-1:0] c_last_chan = P_IDX_WIDTH'(N_CHANNELS - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [P_IDX_WIDTH-1:0]  r_chan;
    logic [P_IDX_WIDTH-1:0]  r_rr_ptr;
    logic [P_IDX_WIDTH-1:0]  w_pick;
    logic [N_CHANNELS-1:0]   w_req;
    logic [N_CHANNELS-1:0]   w_sel;
    logic                    w_any_req;
    logic                    w_grant;
    logic                    w_release;
    logic                    w_locked;

    logic [P_HDR_WIDTH-1:0]  w_hdr_arr  [N_CHANNELS];
    logic [P_DATA_WIDTH-1:0] w_data_arr [N_CHANNELS];

    // First requesting channel at or after ptr, wrapping N-1 -> 0. The scan
    // runs from the farthest offset down so the nearest hit is written last.
    function automatic logic [P_IDX_WIDTH-1:0] f_rr_pick(
        input logic [N_CHANNELS-1:0]  req,
        input logic [P_IDX_WIDTH-1:0] ptr
    );
        logic [P_IDX_WIDTH-1:0] pick;
        int                     k;
        pick = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N_CHANNELS) begin
                k = k - N_CHANNELS;
            end
            if (req[k[P_IDX_WIDTH-1:0]]) begin
                pick = k[P_IDX_WIDTH-1:0];
            end
        end
        return pick;
    endfunction

    assign w_req     = ~wvb_hdr_empty & ~chan_mask;
    assign w_any_req = |w_req;
    assign w_pick    = f_rr_pick(w_req, r_rr_ptr);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            c_idle: begin
                if (en && w_any_req) begin
                    w_state_nxt = c_lock;
                    w_grant     = 1'b1;
                end
            end
            c_lock: begin
                if (dn_rddone) begin
                    w_state_nxt = c_rel;
                    w_release   = 1'b1;
                end
            end
            c_rel: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (one-hot route of the locked channel)
    // ------------------------------------------------------------------
    always_comb begin
        w_locked = (r_state == c_lock);
        w_sel    = '0;
        if (w_locked) begin
            w_sel[r_chan] = 1'b1;
        end
    end

    // Locked channel and next scan start; rr_ptr only moves on release so a
    // lone requester is found again by wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chan   <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_grant) begin
                r_chan <= w_pick;
            end
            if (w_release) begin
                r_rr_ptr <= (r_chan == c_last_chan) ? '0 : r_chan + 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < N_CHANNELS; g++) begin : g_unpack
            assign w_hdr_arr[g]  = wvb_hdr_data[g*P_HDR_WIDTH +: P_HDR_WIDTH];
            assign w_data_arr[g] = wvb_data[g*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
    endgenerate

    // Strobes pass straight through so upstream read latency is unchanged.
    assign wvb_hdr_rdreq = w_sel & {N_CHANNELS{dn_hdr_rdreq}};
    assign wvb_rdreq     = w_sel & {N_CHANNELS{dn_rdreq}};
    assign wvb_rddone    = w_sel & {N_CHANNELS{dn_rddone}};

    assign dn_locked     = w_locked;
    assign dn_chan       = r_chan;
    assign dn_hdr_empty  = ~w_locked | wvb_hdr_empty[r_chan];
    assign dn_hdr_data   = w_locked ? w_hdr_arr[r_chan]  : '0;
    assign dn_data       = w_locked ? w_data_arr[r_chan] : '0;

`ifdef WVB_ARB_GRANT_CNT_EN
    generate
        for (genvar g = 0; g < N_CHANNELS; g++) begin : g_grant_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_grant && (w_pick == P_IDX_WIDTH'(g)) && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign grant_cnt[g*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_wvb_chan_arbiter.sv
`default_nettype none
// Testbench for wvb_chan_arbiter: directed scenarios and randomized traffic,
// compared every cycle against a transaction-level arbitration model.
module tb_wvb_chan_arbiter;

    localparam int N  = 24;
    localparam int IW = 5;
    localparam int DW = 170;
    localparam int HW = 113;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [N-1:0]      chan_mask;
    logic [N-1:0]      wvb_hdr_empty;
    logic [N*HW-1:0]   wvb_hdr_data;
    logic [N*DW-1:0]   wvb_data;
    logic [N-1:0]      wvb_hdr_rdreq;
    logic [N-1:0]      wvb_rdreq;
    logic [N-1:0]      wvb_rddone;
    logic              dn_hdr_empty;
    logic [HW-1:0]     dn_hdr_data;
    logic [DW-1:0]     dn_data;
    logic [IW-1:0]     dn_chan;
    logic              dn_locked;
    logic              dn_hdr_rdreq;
    logic              dn_rdreq;
    logic              dn_rddone;
`ifdef WVB_ARB_GRANT_CNT_EN
    logic [N*16-1:0]   grant_cnt;
`endif

    always #5 clk = ~clk;

    wvb_chan_arbiter #(
        .N_CHANNELS   (N),
        .P_IDX_WIDTH  (IW),
        .P_DATA_WIDTH (DW),
        .P_HDR_WIDTH  (HW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .chan_mask     (chan_mask),
        .wvb_hdr_empty (wvb_hdr_empty),
        .wvb_hdr_data  (wvb_hdr_data),
        .wvb_data      (wvb_data),
        .wvb_hdr_rdreq (wvb_hdr_rdreq),
        .wvb_rdreq     (wvb_rdreq),
        .wvb_rddone    (wvb_rddone),
        .dn_hdr_empty  (dn_hdr_empty),
        .dn_hdr_data   (dn_hdr_data),
        .dn_data       (dn_data),
        .dn_chan       (dn_chan),
        .dn_locked     (dn_locked),
`ifdef WVB_ARB_GRANT_CNT_EN
        .grant_cnt     (grant_cnt),
`endif
        .dn_hdr_rdreq  (dn_hdr_rdreq),
        .dn_rdreq      (dn_rdreq),
        .dn_rddone     (dn_rddone)
    );

    // Reference model: lock flag, owner, scan start and a settle countdown.
    bit  m_locked;
    int  m_chan;
    int  m_ptr;
    int  m_cool;
    int  m_cnt [N];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  lock_age = 0;
    bit  prev_locked = 1'b0;
    int  grants    [$];
    int  grant_cyc [$];

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_chan   = 0;
        m_ptr    = 0;
        m_cool   = 0;
        lock_age = 0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    task automatic model_advance();
        logic [N-1:0] req;
        int           c;
        req = ~wvb_hdr_empty & ~chan_mask;
        if (rst) begin
            model_reset();
        end else if (m_locked) begin
            if (dn_rddone) begin
                m_locked = 1'b0;
                m_ptr    = (m_chan + 1) % N;
                m_cool   = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (en) begin
            for (int off = N - 1; off >= 0; off--) begin
                c = (m_ptr + off) % N;
                if (req[c]) begin
                    m_chan   = c;
                    m_locked = 1'b1;
                end
            end
            if (m_locked && m_cnt[m_chan] < 65535) m_cnt[m_chan]++;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0]  one;
        logic [N-1:0]  sel;
        logic [HW-1:0] exp_hdr;
        logic [DW-1:0] exp_dat;
        one = 1;
        sel = m_locked ? (one << m_chan) : '0;
        exp_hdr = m_locked ? wvb_hdr_data[m_chan*HW +: HW] : '0;
        exp_dat = m_locked ? wvb_data[m_chan*DW +: DW] : '0;
        check_val("dn_locked",     256'(dn_locked),     256'(m_locked));
        check_val("dn_chan",       256'(dn_chan),       256'(m_chan));
        check_val("dn_hdr_empty",  256'(dn_hdr_empty),  256'(m_locked ? wvb_hdr_empty[m_chan] : 1'b1));
        check_val("dn_hdr_data",   256'(dn_hdr_data),   256'(exp_hdr));
        check_val("dn_data",       256'(dn_data),       256'(exp_dat));
        check_val("wvb_hdr_rdreq", 256'(wvb_hdr_rdreq), 256'(sel & {N{dn_hdr_rdreq}}));
        check_val("wvb_rdreq",     256'(wvb_rdreq),     256'(sel & {N{dn_rdreq}}));
        check_val("wvb_rddone",    256'(wvb_rddone),    256'(sel & {N{dn_rddone}}));
`ifdef WVB_ARB_GRANT_CNT_EN
        for (int k = 0; k < N; k++)
            check_val("grant_cnt", 256'(grant_cnt[k*16 +: 16]), 256'(m_cnt[k]));
`endif
        if (dn_locked && !prev_locked) begin
            grants.push_back(int'(dn_chan));
            grant_cyc.push_back(cyc);
        end
        prev_locked = dn_locked;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cycle();
        #1;
        check_outputs();
        model_advance();
        if (m_locked) lock_age++;
        else          lock_age = 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic randomize_data();
        for (int k = 0; k < N; k++) begin
            wvb_hdr_data[k*HW +: HW] = HW'({$urandom, $urandom, $urandom, $urandom});
            wvb_data[k*DW +: DW]     = DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        end
    endtask

    // Consumer holds each lock for hold+1 cycles, then pulses rddone.
    task automatic run_cycles(input int n, input int hold);
        for (int i = 0; i < n; i++) begin
            dn_rddone    = m_locked && (lock_age > hold);
            dn_rdreq     = 1'($urandom);
            dn_hdr_rdreq = 1'($urandom);
            randomize_data();
            cycle();
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        model_reset();
        dn_hdr_rdreq = 1'b1;
        dn_rdreq     = 1'b1;
        dn_rddone    = 1'b1;
        cycle();
        cycle();
        rst          = 1'b0;
        dn_rddone    = 1'b0;
        grants.delete();
        grant_cyc.delete();
    endtask

    task automatic wait_lock(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (dn_locked) seen = 1'b1;
            else begin
                dn_rddone = 1'b0;
                cycle();
            end
        end
        if (!seen && dn_locked) seen = 1'b1;
        check_val(tag, 256'(seen), 256'(1));
    endtask

    logic [N-1:0] one_hot;

    initial begin
        rst           = 1'b1;
        en            = 1'b1;
        chan_mask     = '0;
        wvb_hdr_empty = '1;
        dn_hdr_rdreq  = 1'b0;
        dn_rdreq      = 1'b0;
        dn_rddone     = 1'b0;
        randomize_data();
        model_reset();
        @(negedge clk);

        // 1. reset values, then idle with every header FIFO empty
        do_reset();
        run_cycles(4, 0);
        check_val("t1_idle_grants", 256'(grants.size()), 256'(0));

        // 2. only channel 23 requests: repeated re-lock on 23
        do_reset();
        one_hot = 1;
        wvb_hdr_empty = ~(one_hot << 23);
        run_cycles(20, 2);
        check_val("t2_grant_count", 256'(grants.size() >= 2), 256'(1));
        foreach (grants[i]) check_val("t2_grant_chan", 256'(grants[i]), 256'(23));

        // 3. channels 0,5,23 always pending, immediate release
        do_reset();
        wvb_hdr_empty = '1;
        wvb_hdr_empty[0] = 1'b0;
        wvb_hdr_empty[5] = 1'b0;
        wvb_hdr_empty[23] = 1'b0;
        run_cycles(17, 0);
        check_val("t3_grant_count", 256'(grants.size() >= 5), 256'(1));
        if (grants.size() >= 5) begin
            check_val("t3_order0", 256'(grants[0]), 256'(0));
            check_val("t3_order1", 256'(grants[1]), 256'(5));
            check_val("t3_order2", 256'(grants[2]), 256'(23));
            check_val("t3_order3", 256'(grants[3]), 256'(0));
            check_val("t3_order4", 256'(grants[4]), 256'(5));
            for (int i = 1; i < 5; i++)
                check_val("t3_spacing", 256'(grant_cyc[i] - grant_cyc[i-1]), 256'(3));
        end

        // 4. mask channel 5 while channel 0 holds the lock
        do_reset();
        wait_lock("t4_lock_timeout", 10);
        check_val("t4_first_chan", 256'(dn_chan), 256'(0));
        chan_mask[5] = 1'b1;
        run_cycles(24, 3);
        check_val("t4_grant_count", 256'(grants.size() >= 3), 256'(1));
        if (grants.size() >= 3) begin
            check_val("t4_order0", 256'(grants[0]), 256'(0));
            check_val("t4_order1", 256'(grants[1]), 256'(23));
            check_val("t4_order2", 256'(grants[2]), 256'(0));
        end
        foreach (grants[i]) check_val("t4_no_ch5", 256'(grants[i] == 5), 256'(0));
        chan_mask = '0;

        // 5. drop en while channel 5 is locked
        do_reset();
        wvb_hdr_empty = '1;
        wvb_hdr_empty[5] = 1'b0;
        wvb_hdr_empty[23] = 1'b0;
        wait_lock("t5_lock_timeout", 10);
        check_val("t5_first_chan", 256'(dn_chan), 256'(5));
        en = 1'b0;
        run_cycles(15, 3);
        check_val("t5_grants_en_off", 256'(grants.size()), 256'(1));
        check_val("t5_unlocked", 256'(dn_locked), 256'(0));
        en = 1'b1;
        grants.delete();
        run_cycles(3, 3);
        check_val("t5_regrant_count", 256'(grants.size()), 256'(1));
        if (grants.size() >= 1) check_val("t5_regrant_chan", 256'(grants[0]), 256'(23));

        // 6. asynchronous reset in the middle of a lock
        do_reset();
        wvb_hdr_empty = '1;
        wvb_hdr_empty[0] = 1'b0;
        wait_lock("t6_lock_timeout", 10);
        dn_rdreq     = 1'b1;
        dn_hdr_rdreq = 1'b1;
        dn_rddone    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_val("t6_async_rdreq", 256'(wvb_rdreq), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        run_cycles(6, 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) chan_mask = N'($urandom & $urandom & $urandom);
            for (int k = 0; k < N; k++) wvb_hdr_empty[k] = ($urandom_range(0, 9) < 7);
            en           = ($urandom_range(0, 9) != 0);
            dn_hdr_rdreq = 1'($urandom);
            dn_rdreq     = 1'($urandom);
            dn_rddone    = ($urandom_range(0, 4) == 0);
            randomize_data();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
